layer_sequencer: RTL and testbench

- Sequences one fully-connected layer through the shared combinational neuron datapath: pointwise multiply, accumulate, then ReLU or leaky-ReLU slope.
- For each neuron index it addresses the weight ROM, waits for the weight row to land, captures the datapath result and streams it out with valid/ready handshake.
- Sits between the network-level controller (start/done) and the next layer's input buffer (result stream).
- The y_out activation vector is held static by the upstream controller for the whole layer run; it is not routed through this block.

---
 rtl/layer_sequencer_if.sv | 36 +++
 rtl/layer_sequencer.sv | 104 ++++++++++
 tb/tb_layer_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Handshake/bus bundle between layer_sequencer and its neighbours:
// network controller (start/done), weight ROM/datapath, and result stream.
interface layer_sequencer_if #(
  parameter int BITWIDTH = 16,
  parameter int IDX_W    = 4
);
  logic                start;
  logic [IDX_W:0]      layer_len;
  logic                abort;
  logic                ready;
  logic                busy;
  logic                done;
  logic                w_rd_en;
  logic [IDX_W-1:0]    w_rd_addr;
  logic [BITWIDTH-1:0] neuron_value;
  logic                res_valid;
  logic                res_ready;
  logic [BITWIDTH-1:0] res_data;
  logic [IDX_W-1:0]    res_idx;
  logic                res_last;
  logic [15:0]         stall_cnt;

  // Sequencer side
  modport master (
    input  start, layer_len, abort, neuron_value, res_ready,
    output ready, busy, done, w_rd_en, w_rd_addr,
           res_valid, res_data, res_idx, res_last, stall_cnt
  );

  // Controller / ROM / consumer side
  modport slave (
    output start, layer_len, abort, neuron_value, res_ready,
    input  ready, busy, done, w_rd_en, w_rd_addr,
           res_valid, res_data, res_idx, res_last, stall_cnt
  );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks one fully-connected layer neuron by neuron.
// Per neuron: FETCH (ROM strobe) -> WAIT (datapath settles, capture) ->
// EMIT (hold result until the consumer takes it). 3 cycles/neuron unstalled.
// Optional macro LAYER_SEQ_STALL_CNT_EN builds a saturating backpressure
// counter on stall_cnt; without it stall_cnt is tied to 0.
module layer_sequencer #(
  parameter int BITWIDTH    = 16,
  parameter int MAX_NEURONS = 16,
  parameter int IDX_W       = 4
) (
  input logic clk,
  input logic rst_n,
  layer_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_e;

  localparam logic [IDX_W:0]   MAX_LEN = (IDX_W+1)'(MAX_NEURONS);
  localparam logic [IDX_W:0]   LEN_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W:0]      len_q;
  logic [BITWIDTH-1:0] res_data_q;
  logic [IDX_W-1:0]    res_idx_q;
  logic                res_last_q;
  logic                start_ok;
  logic                xfer;

  assign start_ok = (state_q == IDLE) && bus.start;
  // abort wins over a same-cycle handshake: the word is treated as undelivered
  assign xfer     = (state_q == EMIT) && bus.res_ready && !bus.abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.layer_len == '0) ? DONE : FETCH;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = EMIT;
      EMIT:    if (bus.res_ready) state_d = res_last_q ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
  end

  // Run length / neuron index and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      len_q      <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
      res_last_q <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q <= (bus.layer_len > MAX_LEN) ? MAX_LEN : bus.layer_len;
        idx_q <= '0;
      end
      if (state_q == WAIT) begin
        // value stored verbatim; sign is irrelevant to sequencing
        res_data_q <= bus.neuron_value;
        res_idx_q  <= idx_q;
        res_last_q <= ({1'b0, idx_q} == (len_q - LEN_ONE));
      end
      if (xfer && !res_last_q) idx_q <= idx_q + IDX_ONE;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.w_rd_en   = (state_q == FETCH);
  assign bus.w_rd_addr = idx_q;
  assign bus.res_valid = (state_q == EMIT);
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_last  = res_last_q;

`ifdef LAYER_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count cycles a valid result sits unaccepted; cleared per run, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (start_ok)
      stall_q <= '0;
    else if (bus.res_valid && !bus.res_ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: table of layer runs, directed abort/reset
// sequences, then randomized runs against a per-run reference model.
module tb_layer_sequencer;
  localparam int BW = 16;
  localparam int IW = 4;
  localparam int MAXN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_sequencer_if #(.BITWIDTH(BW), .IDX_W(IW)) ifc ();

  layer_sequencer #(.BITWIDTH(BW), .MAX_NEURONS(MAXN), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  // Weight ROM + datapath model: value appears the cycle after the strobe,
  // garbage otherwise so a mistimed capture shows up.
  logic [BW-1:0] rom [0:MAXN-1];
  logic          rom_v;
  logic [IW-1:0] rom_a;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_v <= 1'b0;
      rom_a <= '0;
    end else begin
      rom_v <= ifc.w_rd_en;
      rom_a <= ifc.w_rd_addr;
    end
  end
  assign ifc.neuron_value = rom_v ? rom[rom_a] : 16'hDEAD;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_stall(input int stalls);
`ifdef LAYER_SEQ_STALL_CNT_EN
    return stalls;
`else
    return 0;
`endif
  endfunction

  // One layer run. Model: n = min(len,MAXN) results, result k carries rom[k],
  // last only on k=n-1, done after 3n+1 cycles plus one per stalled cycle.
  task automatic run(input int len_in, input int pct, input int sidx,
                     input int slen, input bit poke, input int exp_cyc);
    int n, got, cyc, stalls, sdone, fetches;
    bit rdy, pstall, fin;
    logic [BW-1:0] pdata;
    logic [IW-1:0] pidx;
    n = (len_in > MAXN) ? MAXN : len_in;
    got = 0; stalls = 0; sdone = 0; fetches = 0; pstall = 0; fin = 0;
    pdata = '0; pidx = '0;
    ifc.start = 1'b1;
    ifc.layer_len = len_in[IW:0];
    ifc.res_ready = 1'b0;
    step();
    cyc = 1;
    ifc.start = 1'b0;
    check("stall_cnt_cleared", ifc.stall_cnt, 0);
    while (cyc < 2000) begin
      if (ifc.done) begin
        fin = 1;
        break;
      end
      if (ifc.w_rd_en) fetches++;
      if (pstall) begin
        check("hold_data", ifc.res_data, pdata);
        check("hold_idx", ifc.res_idx, pidx);
      end
      if (ifc.res_valid && ifc.w_rd_en) check("fetch_during_emit", ifc.w_rd_en, 0);
      rdy = ($urandom_range(99) < pct);
      if (ifc.res_valid && ifc.res_idx == sidx && sdone < slen) begin
        rdy = 0;
        sdone++;
      end
      ifc.res_ready = rdy;
      ifc.start = poke && ifc.busy;
      ifc.layer_len = 5'd2;
      if (ifc.res_valid && rdy) begin
        check("res_idx", ifc.res_idx, got);
        check("res_data", ifc.res_data, rom[got % MAXN]);
        check("res_last", ifc.res_last, (got == n - 1));
        got++;
      end
      if (ifc.res_valid && !rdy) stalls++;
      pstall = ifc.res_valid && !rdy;
      pdata = ifc.res_data;
      pidx = ifc.res_idx;
      step();
      cyc++;
    end
    ifc.start = 1'b0;
    check("run_finished", fin, 1);
    check("done_cycle", cyc, 3 * n + 1 + stalls);
    if (exp_cyc >= 0) check("table_cycles", cyc, exp_cyc);
    check("n_results", got, n);
    check("n_fetches", fetches, n);
    check("stall_cnt", ifc.stall_cnt, exp_stall(stalls));
    ifc.res_ready = 1'b0;
    step();
    check("ready_after_done", {ifc.ready, ifc.busy, ifc.done}, 3'b100);
    check("stall_cnt_hold", ifc.stall_cnt, exp_stall(stalls));
  endtask

  typedef struct {
    int len; int pct; int sidx; int slen; int neg_idx; bit poke; int exp_cyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int k;
    bit seen_done;
    vecs[0] = '{4,   100, -1, 0, -1, 1'b0, 13};
    vecs[1] = '{0,   100, -1, 0, -1, 1'b0, 1};
    vecs[2] = '{3,   100,  1, 5,  1, 1'b0, 15};
    vecs[3] = '{1,   100, -1, 0, -1, 1'b0, 4};
    vecs[4] = '{16,  100, -1, 0, -1, 1'b0, 49};
    vecs[5] = '{20,  100, -1, 0, -1, 1'b1, 49};
    vecs[6] = '{31,  100, -1, 0,  7, 1'b0, 49};
    vecs[7] = '{2,   100,  0, 3, -1, 1'b0, 10};

    ifc.start = 1'b0; ifc.layer_len = '0; ifc.abort = 1'b0; ifc.res_ready = 1'b0;
    for (int i = 0; i < MAXN; i++) rom[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rst_ready_busy_done", {ifc.ready, ifc.busy, ifc.done}, 3'b100);
    check("rst_fetch", {ifc.w_rd_en, ifc.w_rd_addr}, 0);
    check("rst_res", {ifc.res_valid, ifc.res_data, ifc.res_idx, ifc.res_last}, 0);
    check("rst_stall_cnt", ifc.stall_cnt, 0);

    // Table-driven runs
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < MAXN; i++) rom[i] = 16'(16'h0100 * (i + 1));
      if (vecs[v].neg_idx >= 0) rom[vecs[v].neg_idx] = 16'hFF80;
      run(vecs[v].len, vecs[v].pct, vecs[v].sidx, vecs[v].slen, vecs[v].poke, vecs[v].exp_cyc);
    end

    // Abort in EMIT of idx 2 together with res_ready
    for (int i = 0; i < MAXN; i++) rom[i] = 16'(16'h0100 * (i + 1));
    ifc.start = 1'b1; ifc.layer_len = 5'd8; ifc.res_ready = 1'b1;
    step();
    ifc.start = 1'b0;
    k = 0;
    while (!(ifc.res_valid && ifc.res_idx == 4'd2) && k < 50) begin step(); k++; end
    check("abort_reach_emit2", (k < 50), 1);
    ifc.abort = 1'b1;
    step();
    ifc.abort = 1'b0; ifc.res_ready = 1'b0;
    check("abort_idle", {ifc.ready, ifc.busy, ifc.done, ifc.res_valid, ifc.w_rd_en}, 5'b10000);
    seen_done = 0;
    repeat (4) begin step(); if (ifc.done || ifc.busy) seen_done = 1; end
    check("abort_no_done", seen_done, 0);
    run(2, 100, -1, 0, 0, 7);

    // Asynchronous reset during WAIT of idx 1
    ifc.start = 1'b1; ifc.layer_len = 5'd4; ifc.res_ready = 1'b1;
    step();
    ifc.start = 1'b0;
    k = 0;
    while (!(ifc.w_rd_en && ifc.w_rd_addr == 4'd1) && k < 50) begin step(); k++; end
    check("rst_reach_fetch1", (k < 50), 1);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready_busy_done", {ifc.ready, ifc.busy, ifc.done}, 3'b100);
    check("arst_fetch", {ifc.w_rd_en, ifc.w_rd_addr}, 0);
    check("arst_res", {ifc.res_valid, ifc.res_data, ifc.res_idx, ifc.res_last}, 0);
    check("arst_stall_cnt", ifc.stall_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    ifc.res_ready = 1'b0;
    seen_done = 0;
    repeat (4) begin step(); if (ifc.done || ifc.busy) seen_done = 1; end
    check("arst_no_done", seen_done, 0);

    // Randomized runs with random ROM contents and backpressure
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < MAXN; i++) rom[i] = 16'($urandom);
      run(int'($urandom_range(0, 20)), int'($urandom_range(30, 100)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
